// File: rtl/button_arbiter.sv
// button_arbiter
// Debounces four raw push-buttons and turns them into single events on a
// valid/ready interface. One button at a time owns the shared lockout
// counter; the others wait in the synchronizers until the FSM is idle again,
// at which point a round-robin search picks the next owner.
//
// Optional feature: define BUTTON_LONG_PRESS_EN to add long-press events
// (Event_Long=1) and the Drop pulse for a long-press that finds the event
// slot still occupied. Without it, Event_Long and Drop are constant 0.

module button_arbiter #(
   parameter int LOCK_CYCLES = 2000000,
   parameter int LONG_CYCLES = 50000000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Button,
   input  logic       Event_Ready,
   output logic       Event_Valid,
   output logic [1:0] Event_Id,
   output logic       Event_Long,
   output logic       Busy,
   output logic       Drop
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOCK     = 2'd1,
      WAIT_REL = 2'd2,
      RLOCK    = 2'd3
   } state_t;

   // Terminal count of a lockout window: the counter runs 0 .. LOCK_CYCLES-1.
   localparam logic [25:0] LOCK_LAST = 26'(LOCK_CYCLES - 1);

`ifdef BUTTON_LONG_PRESS_EN
   // Counter value, measured from the grant, at which a hold becomes long.
   localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);
`endif

   // Both timing parameters must fit the 26-bit counter and be ordered.
   if (LOCK_CYCLES < 1 || LONG_CYCLES <= LOCK_CYCLES || LONG_CYCLES >= (1 << 26)) begin : g_bad_cycles
      $error("button_arbiter: need 0 < LOCK_CYCLES < LONG_CYCLES < 2**26");
   end

   // ------------------------------------------------------------------
   // Round-robin search: first requester after prev, wrapping mod 4.
   // ------------------------------------------------------------------
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] prev);
      logic [1:0] pick;
      logic       found;
      pick  = prev;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!found && req[prev + 2'(k)]) begin
            pick  = prev + 2'(k);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // ------------------------------------------------------------------
   // Synchronizer
   // ------------------------------------------------------------------
   logic [3:0] sync_meta;
   logic [3:0] sync_s;

   // Two-flop synchronizer per button; the FSM only ever looks at sync_s.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its source, independent of statement order.
      if (Reset) begin
         sync_meta <= 4'd0;
         sync_s    <= 4'd0;
      end else begin
         sync_meta <= Button;
         sync_s    <= sync_meta;
      end
   end

   // ------------------------------------------------------------------
   // FSM and event registers
   // ------------------------------------------------------------------
   state_t      state, state_nxt;
   logic [25:0] count, count_nxt;
   logic [1:0]  grant, grant_nxt;
   logic [1:0]  last, last_nxt;
   logic        valid, valid_nxt;
   logic [1:0]  id, id_nxt;
   logic [1:0]  rr_win;

`ifdef BUTTON_LONG_PRESS_EN
   logic        ev_long, long_nxt;
   logic        drop, drop_nxt;
   logic        long_done, long_done_nxt;
`endif

   assign rr_win = rr_pick(sync_s, last);

   // State, counter, grant bookkeeping and the event slot.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         count     <= 26'd0;
         grant     <= 2'd0;
         last      <= 2'd3;
         valid     <= 1'b0;
         id        <= 2'd0;
`ifdef BUTTON_LONG_PRESS_EN
         ev_long   <= 1'b0;
         drop      <= 1'b0;
         long_done <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         grant     <= grant_nxt;
         last      <= last_nxt;
         valid     <= valid_nxt;
         id        <= id_nxt;
`ifdef BUTTON_LONG_PRESS_EN
         ev_long   <= long_nxt;
         drop      <= drop_nxt;
         long_done <= long_done_nxt;
`endif
      end
   end

   // Next-state, counter and event-slot logic.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_nxt = state;
      count_nxt = count;
      grant_nxt = grant;
      last_nxt  = last;
      valid_nxt = valid & ~Event_Ready;
      id_nxt    = id;
`ifdef BUTTON_LONG_PRESS_EN
      long_nxt      = ev_long;
      drop_nxt      = 1'b0;
      long_done_nxt = long_done;
`endif

      unique case (state)
         IDLE: begin
            // A pending event blocks new grants; requests simply stay
            // asserted in the synchronizer until the slot frees up.
            if (sync_s != 4'd0 && !valid) begin
               grant_nxt = rr_win;
               last_nxt  = rr_win;
               count_nxt = 26'd0;
               valid_nxt = 1'b1;
               id_nxt    = rr_win;
`ifdef BUTTON_LONG_PRESS_EN
               long_nxt      = 1'b0;
               long_done_nxt = 1'b0;
`endif
               state_nxt = LOCK;
            end
         end

         LOCK: begin
            if (count == LOCK_LAST) begin
               if (sync_s[grant]) begin
                  state_nxt = WAIT_REL;
`ifdef BUTTON_LONG_PRESS_EN
                  // Keep counting from the grant so the long-press
                  // threshold is measured from the original press.
                  count_nxt = count + 26'd1;
`else
                  count_nxt = 26'd0;
`endif
               end else begin
                  state_nxt = RLOCK;
                  count_nxt = 26'd0;
               end
            end else begin
               count_nxt = count + 26'd1;
            end
         end

         WAIT_REL: begin
            if (!sync_s[grant]) begin
               count_nxt = 26'd0;
               state_nxt = RLOCK;
            end
`ifdef BUTTON_LONG_PRESS_EN
            else if (!long_done) begin
               count_nxt = count + 26'd1;
               if (count == LONG_LAST) begin
                  long_done_nxt = 1'b1;
                  // The slot may be reused in the cycle it is accepted;
                  // only a still-pending event forces a drop.
                  if (valid && !Event_Ready) begin
                     drop_nxt = 1'b1;
                  end else begin
                     valid_nxt = 1'b1;
                     id_nxt    = grant;
                     long_nxt  = 1'b1;
                  end
               end
            end
`endif
         end

         RLOCK: begin
            if (count == LOCK_LAST) begin
               state_nxt = IDLE;
            end else begin
               count_nxt = count + 26'd1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign Event_Valid = valid;
   assign Event_Id    = id;
   assign Busy        = (state != IDLE);

`ifdef BUTTON_LONG_PRESS_EN
   assign Event_Long  = ev_long;
   assign Drop        = drop;
`else
   assign Event_Long  = 1'b0;
   assign Drop        = 1'b0;
`endif

endmodule

// File: tb/tb_button_arbiter.sv
// tb_button_arbiter
// Directed scenarios followed by a random phase. A timestamp-based reference
// model (grant time, release-lock start time) predicts every output each cycle.

module tb_button_arbiter;

   localparam int LOCK_C = 8;
   localparam int LONG_C = 20;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [3:0] Button;
   logic       Event_Ready;
   logic       Event_Valid;
   logic [1:0] Event_Id;
   logic       Event_Long;
   logic       Busy;
   logic       Drop;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 Clk = ~Clk;

   button_arbiter #(
      .LOCK_CYCLES(LOCK_C),
      .LONG_CYCLES(LONG_C)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Button      (Button),
      .Event_Ready (Event_Ready),
      .Event_Valid (Event_Valid),
      .Event_Id    (Event_Id),
      .Event_Long  (Event_Long),
      .Busy        (Busy),
      .Drop        (Drop)
   );

   // ------------------------------------------------------------------
   // Reference model: phases defined by timestamps, not a counter.
   // phase 0 idle, 1 press lockout, 2 waiting for release, 3 release lockout
   // ------------------------------------------------------------------
   logic [3:0] m_sync1 = 4'd0, m_s = 4'd0, s_old;
   logic       v_old;
   int         m_phase = 0, m_edge = 0, m_grant_t = 0, m_rlock_t = 0;
   int         m_g = 0, m_last = 3;
   logic       m_valid = 1'b0, m_long = 1'b0, m_drop = 1'b0, m_done = 1'b0;
   logic [1:0] m_id = 2'd0;

   always @(posedge Clk) begin
      m_edge++;
      if (Reset) begin
         m_sync1 = 4'd0; m_s = 4'd0; m_phase = 0; m_last = 3; m_g = 0;
         m_valid = 1'b0; m_id = 2'd0; m_long = 1'b0; m_drop = 1'b0; m_done = 1'b0;
      end else begin
         s_old   = m_s;
         v_old   = m_valid;
         m_s     = m_sync1;
         m_sync1 = Button;
         m_drop  = 1'b0;
         if (m_valid && Event_Ready) m_valid = 1'b0;
         case (m_phase)
            0: if (s_old != 4'd0 && !v_old) begin
                  for (int k = 1; k <= 4; k++) begin
                     if (s_old[(m_last + k) % 4]) begin
                        m_g = (m_last + k) % 4;
                        break;
                     end
                  end
                  m_last = m_g; m_grant_t = m_edge; m_done = 1'b0;
                  m_valid = 1'b1; m_id = 2'(m_g); m_long = 1'b0;
                  m_phase = 1;
               end
            1: if (m_edge == m_grant_t + LOCK_C) begin
                  if (s_old[m_g]) m_phase = 2;
                  else begin m_phase = 3; m_rlock_t = m_edge; end
               end
            2: if (!s_old[m_g]) begin
                  m_phase = 3; m_rlock_t = m_edge;
               end
`ifdef BUTTON_LONG_PRESS_EN
               else if (!m_done && m_edge == m_grant_t + LONG_C) begin
                  m_done = 1'b1;
                  if (v_old && !Event_Ready) m_drop = 1'b1;
                  else begin m_valid = 1'b1; m_id = 2'(m_g); m_long = 1'b1; end
               end
`endif
            default: if (m_edge == m_rlock_t + LOCK_C) m_phase = 0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Checking helpers and DUT event observation
   // ------------------------------------------------------------------
   logic       prev_valid = 1'b0;
   int         rise_cnt = 0, drop_cnt = 0, rise_first = 0, rise_last = 0;
   logic [1:0] rise_id = 2'd0;
   logic       rise_long = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance one cycle; compare at the falling edge against the model.
   task automatic tick();
      @(negedge Clk);
      cyc++;
      check("m_valid", {31'd0, Event_Valid}, {31'd0, m_valid});
      check("m_id",    {30'd0, Event_Id},    {30'd0, m_id});
      check("m_long",  {31'd0, Event_Long},  {31'd0, m_long});
      check("m_busy",  {31'd0, Busy},        {31'd0, m_phase != 0});
      check("m_drop",  {31'd0, Drop},        {31'd0, m_drop});
      if (Event_Valid === 1'b1 && prev_valid !== 1'b1) begin
         rise_cnt++;
         rise_id   = Event_Id;
         rise_long = Event_Long;
         if (rise_cnt == 1) rise_first = cyc;
         rise_last = cyc;
      end
      if (Drop === 1'b1) drop_cnt++;
      prev_valid = Event_Valid;
   endtask

   task automatic clear_obs();
      rise_cnt = 0; drop_cnt = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (Busy !== 1'b0 && n < 200) begin tick(); n++; end
      check("idle_reached", {31'd0, Busy}, 32'd0);
      repeat (3) tick();
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      logic b[6];

      // Reset with all buttons held: nothing may leak out.
      Reset = 1'b1; Button = 4'hF; Event_Ready = 1'b0;
      tick(); tick();
      check("rst_valid", {31'd0, Event_Valid}, 32'd0);
      check("rst_id",    {30'd0, Event_Id},    32'd0);
      check("rst_long",  {31'd0, Event_Long},  32'd0);
      check("rst_busy",  {31'd0, Busy},        32'd0);
      check("rst_drop",  {31'd0, Drop},        32'd0);
      Reset = 1'b0; Button = 4'h0;
      tick();
      check("post_rst_valid", {31'd0, Event_Valid}, 32'd0);
      check("post_rst_busy",  {31'd0, Busy},        32'd0);
      repeat (3) tick();

      // Two simultaneous buttons, pressed twice: round robin gives 1 then 3.
      Event_Ready = 1'b1;
      clear_obs();
      Button = 4'b1010; repeat (12) tick(); Button = 4'h0; wait_idle();
      check("rr1_count", rise_cnt, 32'd1);
      check("rr1_id",    {30'd0, rise_id}, 32'd1);
      clear_obs();
      Button = 4'b1010; repeat (12) tick(); Button = 4'h0; wait_idle();
      check("rr2_count", rise_cnt, 32'd1);
      check("rr2_id",    {30'd0, rise_id}, 32'd3);

      // Button 2 bounces for six cycles: one event at the third edge.
      clear_obs();
      b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         Button = {1'b0, b[i], 2'b00};
         tick();
         if (i < 2) check("bnc_early_valid", {31'd0, Event_Valid}, 32'd0);
         if (i == 2) begin
            check("bnc_valid_e3", {31'd0, Event_Valid}, 32'd1);
            check("bnc_id_e3",    {30'd0, Event_Id},    32'd2);
         end
         if (i >= 2) check("bnc_busy", {31'd0, Busy}, 32'd1);
      end
      Button = 4'b0100;
      for (int i = 0; i < 6; i++) begin tick(); check("hold_busy", {31'd0, Busy}, 32'd1); end
      Button = 4'b0000; tick(); Button = 4'b0100; tick(); Button = 4'b0000;
      wait_idle();
      repeat (10) tick();
      check("bnc_count", rise_cnt, 32'd1);
      check("bnc_id",    {30'd0, rise_id}, 32'd2);

      // Back-pressure: button 0 pending, button 1 deferred until idle.
      Event_Ready = 1'b0;
      Button = 4'b0001;
      tick(); tick(); tick();
      check("bp_valid_e3", {31'd0, Event_Valid}, 32'd1);
      for (int k = 1; k <= 10; k++) begin
         if (k == 2) Button = 4'b0000;
         if (k == 4) Button = 4'b0010;
         tick();
         check("bp_hold_valid", {31'd0, Event_Valid}, 32'd1);
         check("bp_hold_id",    {30'd0, Event_Id},    32'd0);
      end
      Event_Ready = 1'b1;
      tick();
      check("bp_ack_fall", {31'd0, Event_Valid}, 32'd0);
      clear_obs();
      for (int n = 0; n < 100 && rise_cnt == 0; n++) tick();
      check("bp_deferred_count", rise_cnt, 32'd1);
      check("bp_deferred_id",    {30'd0, rise_id}, 32'd1);
      Button = 4'b0000;
      wait_idle();

      // Long hold on button 0 with the consumer ready.
      clear_obs();
      Button = 4'b0001; repeat (40) tick(); Button = 4'b0000; wait_idle();
`ifdef BUTTON_LONG_PRESS_EN
      check("long_count", rise_cnt, 32'd2);
      check("long_flag",  {31'd0, rise_long}, 32'd1);
      check("long_gap",   rise_last - rise_first, LONG_C);
`else
      check("long_count", rise_cnt, 32'd1);
      check("long_flag",  {31'd0, rise_long}, 32'd0);
`endif
      // Same hold with the consumer stalled: the long event is dropped.
      clear_obs();
      Event_Ready = 1'b0;
      Button = 4'b0001; repeat (40) tick(); Button = 4'b0000; wait_idle();
`ifdef BUTTON_LONG_PRESS_EN
      check("drop_count", drop_cnt, 32'd1);
`else
      check("drop_count", drop_cnt, 32'd0);
`endif
      check("drop_rise_count", rise_cnt, 32'd1);
      Event_Ready = 1'b1;
      tick(); tick();

      // Reset in the middle of a lockout with an event pending.
      Event_Ready = 1'b0;
      Button = 4'b0100;
      tick(); tick(); tick();
      check("mid_valid", {31'd0, Event_Valid}, 32'd1);
      repeat (4) tick();
      Button = 4'b0000; Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_busy",  {31'd0, Busy},        32'd0);
      check("mid_rst_valid", {31'd0, Event_Valid}, 32'd0);
      Event_Ready = 1'b1;
      Button = 4'b1000;
      tick(); tick();
      check("post_mid_early", {31'd0, Event_Valid}, 32'd0);
      tick();
      check("post_mid_valid", {31'd0, Event_Valid}, 32'd1);
      check("post_mid_id",    {30'd0, Event_Id},    32'd3);
      Button = 4'b0000;
      wait_idle();

      // Random buttons, back-pressure and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            int idx;
            idx = int'($urandom_range(0, 3));
            Button[idx] = ~Button[idx];
         end
         Event_Ready = ($urandom_range(0, 3) != 0);
         Reset       = ($urandom_range(0, 599) == 0);
         tick();
      end
      Reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_CYCLES, default 2000000, the debounce lockout length in Clk cycles (20 ms at 100 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50000000, the long-press threshold in Clk cycles; LOCK_CYCLES < LONG_CYCLES < 2^26.
REQ-003 The block SHALL have port Clk, input, 1 bit: sole clock, with all logic on the rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Button, input, 4 bits: raw asynchronous bouncing buttons, active-high.
REQ-006 The block SHALL have port Event_Ready, input, 1 bit: consumer accepts the event.
REQ-007 The block SHALL have port Event_Valid, output, 1 bit: event pending.
REQ-008 The block SHALL have port Event_Id, output, 2 bits: index of the button that caused the event.
REQ-009 The block SHALL have port Event_Long, output, 1 bit: 1 marks a long-press event, 0 marks a press event.
REQ-010 The block SHALL have port Busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port Drop, output, 1 bit: one-cycle pulse when a long-press event is discarded.

Function
REQ-012 Each Button bit SHALL pass through a two-flop synchronizer; the FSM SHALL see only the synchronized value S[3:0].
REQ-013 A single shared 26-bit counter SHALL serve as the debounce timer for all four buttons, and only the granted button SHALL own it.
REQ-014 The FSM SHALL have states IDLE, LOCK, WAIT_REL and RLOCK.
REQ-015 In IDLE with S != 0 and Event_Valid == 0, the FSM SHALL grant round-robin, searching from Last+1 mod 4, latch the winner into G and Last, clear the counter, post a press event (Id=G, Long=0) and enter LOCK.
REQ-016 In IDLE, while Event_Valid == 1, no grant SHALL occur and requests SHALL wait with none lost.
REQ-017 Event_Valid SHALL rise at the third Clk edge at which Button[i] is sampled high, starting from IDLE with no pending event.
REQ-018 In LOCK, the counter SHALL increment every cycle and all S changes SHALL be ignored; at count == LOCK_CYCLES-1 the FSM SHALL go to WAIT_REL if S[G]==1, else to RLOCK with the counter cleared.
REQ-019 In WAIT_REL, when S[G]==0 the FSM SHALL clear the counter and enter RLOCK.
REQ-020 In RLOCK, the FSM SHALL count LOCK_CYCLES cycles while ignoring S, then return to IDLE.
REQ-021 In RLOCK, a held button SHALL be granted again on return to IDLE.
REQ-022 Event_Valid SHALL hold until a cycle with Event_Valid & Event_Ready, and SHALL fall at that edge.
REQ-023 Event_Id and Event_Long SHALL stay stable while Event_Valid is high.
REQ-024 A new event SHALL be allowed in the same cycle as an acceptance.
REQ-025 Events from other buttons arriving during LOCK, WAIT_REL or RLOCK SHALL be deferred until IDLE, not queued in a buffer.
REQ-026 Busy SHALL be combinational from the state: high in LOCK, WAIT_REL and RLOCK.

Reset
REQ-027 Reset SHALL force IDLE, counter=0 and synchronizer flops=0.
REQ-028 Reset SHALL force Last=3, so that button 0 wins first.
REQ-029 Reset SHALL force Event_Valid=0, Event_Id=0, Event_Long=0, Busy=0 and Drop=0.
REQ-030 Reset SHALL take priority over all other inputs in any state, including mid-LOCK or with an event pending, and the pending event SHALL be discarded.

Configuration
REQ-031 When BUTTON_LONG_PRESS_EN is defined, the counter SHALL not be cleared on LOCK→WAIT_REL; in WAIT_REL, when the count reaches LONG_CYCLES-1 with S[G]==1, the block SHALL post one event (Id=G, Long=1) per press.
REQ-032 When BUTTON_LONG_PRESS_EN is defined and Event_Valid is already high at that point, the long-press event SHALL be discarded and Drop SHALL pulse for one cycle.
REQ-033 When BUTTON_LONG_PRESS_EN is undefined, Event_Long and Drop SHALL be tied to 0, no long-press logic SHALL exist, and behaviour SHALL otherwise be identical.

Verification (LOCK_CYCLES=8, LONG_CYCLES=20)
REQ-034 Bench SHALL cover: Reset=1 for 2 cycles with Button=4'hF → all outputs 0 during and 1 cycle after; Busy=0.
REQ-035 Bench SHALL cover: Button[2] rises and bounces for 6 cycles, Event_Ready=1 → exactly one Event_Valid pulse with Id=2, 3 edges after the first sample; Busy=1 for the LOCK duration; no second event.
REQ-036 Bench SHALL cover: Button=4'b1010 held then released, twice, with full lockouts → first Id=1, then Id=3.
REQ-037 Bench SHALL cover: Event_Ready=0 for 10 cycles after a press on button 0 → Event_Valid stays 1 with Id=0 stable; a Button[1] press meanwhile is deferred; after Ready=1 → Valid falls, then an Id=1 event follows.
REQ-038 Bench SHALL cover, with BUTTON_LONG_PRESS_EN: Button[0] held 40 cycles → press event, then a Long=1 event 20 cycles after the grant; with Ready=0 during that → Drop pulses once; without the macro → only the press event.
REQ-039 Bench SHALL cover: Reset pulsed at LOCK count 4 → IDLE; Button[3] pressed after reset → Event_Valid with Id=3 at 3 edges.
